// File: rtl/ecore_mem_arbiter.sv
// ecore_mem_arbiter
//   Shares one single-ported, synchronous-read 32-bit RAM between the
//   instruction fetch port (read-only) and the load/store port. At most one
//   access is granted per cycle and each 1-cycle-latency read response is
//   routed back to the requester that issued it.
//
//   Arbitration:
//     default                  data has priority over fetch, but fetch wins
//                              once data has been granted MAX_STALL times in a
//                              row while fetch was waiting.
//     ECORE_ARB_RR_EN defined  fair round-robin; on contention the side not
//                              granted last wins.
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_if_req/i_if_addr            fetch request (held until o_if_gnt)
//   o_if_gnt                      fetch accepted this cycle (combinational)
//   o_if_rvalid/o_if_rdata        fetch read response
//   i_d_req/addr/we/be/wdata      data request (held until o_d_gnt)
//   o_d_gnt                       data accepted this cycle (combinational)
//   o_d_rvalid/o_d_rdata          load read response (none for stores)
//   o_mem_addr/en/we/be/wdata     RAM command
//   i_mem_rdata                   RAM read data, one cycle after a read
module ecore_mem_arbiter #(
  parameter int unsigned AW        = 30,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [31:0]   o_if_rdata,
  input  logic          i_d_req,
  input  logic [AW-1:0] i_d_addr,
  input  logic          i_d_we,
  input  logic [3:0]    i_d_be,
  input  logic [31:0]   i_d_wdata,
  output logic          o_d_gnt,
  output logic          o_d_rvalid,
  output logic [31:0]   o_d_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [3:0]    o_mem_be,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata
);

  typedef enum logic {SideD, SideIf} side_e;

  side_e       owner_q, owner_d;
  logic        rd_pend_q, rd_pend_d;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        if_win;

`ifdef ECORE_ARB_RR_EN
  side_e rr_last_q, rr_last_d;

  assign if_win = (rr_last_q == SideD);

  always_comb begin
    rr_last_d = rr_last_q;
    if (o_if_gnt) begin
      rr_last_d = SideIf;
    end else if (o_d_gnt) begin
      rr_last_d = SideD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_last_q <= SideD;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  logic [3:0] stall_cnt_q, stall_cnt_d;

  assign if_win = (stall_cnt_q == 4'(MAX_STALL));

  // Counts consecutive data grants taken while fetch was waiting.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!i_if_req || o_if_gnt) begin
      stall_cnt_d = 4'd0;
    end else if (o_d_gnt && (stall_cnt_q < 4'(MAX_STALL))) begin
      stall_cnt_d = stall_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= 4'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

  // Grants are suppressed while reset is asserted.
  assign o_if_gnt = i_if_req & (~i_d_req | if_win) & ~i_rst;
  assign o_d_gnt  = i_d_req & ~o_if_gnt & ~i_rst;

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_be    = 4'b0000;
    o_mem_wdata = 32'd0;
    if (o_if_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_if_addr;
      o_mem_be   = 4'b1111;
    end else if (o_d_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_d_addr;
      o_mem_we   = i_d_we;
      o_mem_be   = i_d_we ? i_d_be : 4'b1111;
      o_mem_wdata = i_d_we ? i_d_wdata : 32'd0;
    end
  end

  always_comb begin
    rd_pend_d = o_if_gnt | (o_d_gnt & ~i_d_we);
    owner_d   = o_if_gnt ? SideIf : SideD;
  end

  // Masking with i_rst drops a read that was in flight when reset arrived.
  assign o_if_rvalid = rd_pend_q & (owner_q == SideIf) & ~i_rst;
  assign o_d_rvalid  = rd_pend_q & (owner_q == SideD) & ~i_rst;

  // RAM data arrives in the response cycle, so pass it straight through and
  // keep a copy for the cycles in between.
  assign o_if_rdata = o_if_rvalid ? i_mem_rdata : if_rdata_q;
  assign o_d_rdata  = o_d_rvalid ? i_mem_rdata : d_rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_pend_q  <= 1'b0;
      owner_q    <= SideD;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      rd_pend_q <= rd_pend_d;
      owner_q   <= owner_d;
      if (o_if_rvalid) begin
        if_rdata_q <= i_mem_rdata;
      end
      if (o_d_rvalid) begin
        d_rdata_q <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ecore_mem_arbiter.sv
module tb_ecore_mem_arbiter;

  localparam int unsigned AW = 30;
  localparam int unsigned MS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_be;
  logic [31:0]   d_wdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  ecore_mem_arbiter #(.AW(AW), .MAX_STALL(MS)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_addr(d_addr), .i_d_we(d_we), .i_d_be(d_be),
    .i_d_wdata(d_wdata), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_addr(mem_addr), .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_be(mem_be),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input logic [5:0] a);
    if (a == 6'h10) return 32'hDEADBEEF;
    return ({26'd0, a} * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [3:0] be,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Synchronous-read RAM (64 words used), contents seeded from init_word.
  logic [31:0] ram [64];
  logic [63:0] ram_vld = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[5:0]] <= merge(ram_vld[mem_addr[5:0]] ? ram[mem_addr[5:0]]
                                    : init_word(mem_addr[5:0]), mem_be, mem_wdata);
        ram_vld[mem_addr[5:0]] <= 1'b1;
      end else begin
        mem_rdata <= ram_vld[mem_addr[5:0]] ? ram[mem_addr[5:0]] : init_word(mem_addr[5:0]);
      end
    end
  end

  // Reference model state.
  typedef struct packed {
    logic        is_if;
    logic [31:0] data;
  } resp_t;
  resp_t       exp_q[$];
  logic [31:0] ref_mem [64];
  int          waits;     // consecutive data wins while fetch waited
  logic        last_if;   // last grant went to fetch
  logic [31:0] last_if_data, last_d_data;
  logic        mon_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: predict and check the grant, then advance the model.
  task automatic step(output logic gi, output logic gd);
    logic ei, ed;
    if (rst) exp_q.delete();
    @(negedge clk);
    if (rst) begin
      ei = 1'b0; ed = 1'b0;
    end else if (if_req && d_req) begin
`ifdef ECORE_ARB_RR_EN
      ei = !last_if;
`else
      ei = (waits >= int'(MS));
`endif
      ed = !ei;
    end else begin
      ei = if_req; ed = d_req;
    end
    check("if_gnt", {31'd0, if_gnt}, {31'd0, ei});
    check("d_gnt", {31'd0, d_gnt}, {31'd0, ed});
    check("mem_en", {31'd0, mem_en}, {31'd0, ei | ed});
    if (ei) begin
      check("mem_addr_if", mem_addr, if_addr);
      check("mem_we_if", {31'd0, mem_we}, 32'd0);
      check("mem_be_if", {28'd0, mem_be}, 32'hF);
    end else if (ed) begin
      check("mem_addr_d", mem_addr, d_addr);
      check("mem_we_d", {31'd0, mem_we}, {31'd0, d_we});
      check("mem_be_d", {28'd0, mem_be}, d_we ? {28'd0, d_be} : 32'hF);
      if (d_we) check("mem_wdata", mem_wdata, d_wdata);
    end else begin
      check("mem_we_idle", {31'd0, mem_we}, 32'd0);
    end
    @(posedge clk);
    if (rst) begin
      waits = 0; last_if = 1'b0; last_if_data = 32'd0; last_d_data = 32'd0;
    end else begin
      if (ei) exp_q.push_back('{is_if: 1'b1, data: ref_mem[if_addr[5:0]]});
      if (ed && !d_we) exp_q.push_back('{is_if: 1'b0, data: ref_mem[d_addr[5:0]]});
      if (ed && d_we) ref_mem[d_addr[5:0]] = merge(ref_mem[d_addr[5:0]], d_be, d_wdata);
      if (!if_req || ei) waits = 0;
      else if (ed) waits++;
      if (ei) last_if = 1'b1;
      else if (ed) last_if = 1'b0;
    end
    #1;
    gi = ei; gd = ed;
  endtask

  task automatic new_if();
    if_req  = 1'($urandom_range(0, 1));
    if_addr = AW'($urandom_range(0, 63));
  endtask

  task automatic new_d();
    d_req   = 1'($urandom_range(0, 1));
    d_addr  = AW'($urandom_range(0, 63));
    d_we    = 1'($urandom_range(0, 1));
    d_be    = 4'($urandom);
    d_wdata = $urandom;
  endtask

  // Response monitor: pops the scoreboard whenever a response is presented.
  initial begin
    resp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (if_rvalid && d_rvalid) check("both_rvalid", 32'd1, 32'd0);
      if (if_rvalid || d_rvalid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rvalid_port", {31'd0, if_rvalid}, {31'd0, e.is_if});
          if (e.is_if) begin
            check("if_rdata", if_rdata, e.data);
            last_if_data = e.data;
          end else begin
            check("d_rdata", d_rdata, e.data);
            last_d_data = e.data;
          end
        end
      end else begin
        check("missing_rvalid", 32'(exp_q.size()), 32'd0);
      end
      if (!if_rvalid) check("if_rdata_hold", if_rdata, last_if_data);
      if (!d_rvalid) check("d_rdata_hold", d_rdata, last_d_data);
    end
  end

  initial begin
    logic gi, gd;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(6'(i));
    waits = 0; last_if = 1'b0; last_if_data = 32'd0; last_d_data = 32'd0;

    // Reset with both requests high: nothing may be granted.
    rst = 1'b1;
    if_req = 1'b1; if_addr = AW'(3);
    d_req = 1'b1; d_addr = AW'(4); d_we = 1'b0; d_be = 4'hF; d_wdata = 32'd0;
    step(gi, gd);
    mon_en = 1'b1;
    step(gi, gd);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    step(gi, gd);

    // Fetch only from word 0x10.
    if_req = 1'b1; if_addr = AW'('h10);
    step(gi, gd);
    if_req = 1'b0;
    step(gi, gd);
    step(gi, gd);
    check("fetch_deadbeef", if_rdata, 32'hDEADBEEF);

    // Partial store then load of the same word.
    d_req = 1'b1; d_we = 1'b1; d_addr = AW'(5); d_be = 4'b0011; d_wdata = 32'h12345678;
    step(gi, gd);
    d_we = 1'b0;
    step(gi, gd);
    d_req = 1'b0;
    step(gi, gd);
    check("store_load_low", {16'd0, d_rdata[15:0]}, 32'h5678);

    // Continuous contention straight out of reset.
    rst = 1'b1;
    step(gi, gd);
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(gi, gd);
`ifdef ECORE_ARB_RR_EN
      check($sformatf("contention_%0d", k), {31'd0, gi}, {31'd0, (k % 2) == 0});
`else
      check($sformatf("contention_%0d", k), {31'd0, gi}, {31'd0, (k % 5) == 4});
`endif
      if_addr = AW'($urandom_range(0, 63));
      d_addr  = AW'($urandom_range(0, 63));
    end
    if_req = 1'b0; d_req = 1'b0;
    step(gi, gd);

    // Reset arriving while a load is in flight drops the response.
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(9);
    step(gi, gd);
    d_req = 1'b0; rst = 1'b1;
    step(gi, gd);
    rst = 1'b0;
    step(gi, gd);

    // Randomized traffic, requests held until granted.
    new_if();
    new_d();
    for (int n = 0; n < 400; n++) begin
      step(gi, gd);
      if (gi || !if_req) new_if();
      if (gd || !d_req) new_d();
    end
    if_req = 1'b0; d_req = 1'b0;
    step(gi, gd);
    step(gi, gd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
